// File: rtl/tl_tx_sched.sv
// tl_tx_sched: packet-atomic round-robin scheduler draining N_Q transaction-layer
// queues into one outbound beat stream, gated by per-queue header credits.
//
//   state | meaning
//   IDLE  | arbitrate among eligible queues, no beat output (one-cycle bubble)
//   XFER  | stream beats of the granted packet from queue cur until eop handshake
module tl_tx_sched #(
    parameter int N_Q        = 3,
    parameter int DATA_WIDTH = 256,
    parameter int CRED_W     = 8,
    parameter int INIT_CRED  = 8,
    localparam int QW        = (N_Q > 1) ? $clog2(N_Q) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_Q-1:0]            q_empty_i,
    input  logic [N_Q*DATA_WIDTH-1:0] q_rdata_i,
    input  logic [N_Q-1:0]            q_eop_i,
    output logic [N_Q-1:0]            q_rden_o,
    input  logic [N_Q-1:0]            cred_ret_i,
    output logic [N_Q*CRED_W-1:0]     cred_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    output logic                      out_sop_o,
    output logic                      out_eop_o,
    output logic [QW-1:0]             out_qid_o,
    output logic                      busy_o,
    output logic [31:0]               debug_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1
    } state_t;

    state_t            state_q, state_d;
    logic [QW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [QW-1:0]     cur_q, cur_d;
    logic              sop_pend_q, sop_pend_d;
    logic [CRED_W-1:0] cred_q [N_Q];
    logic [7:0]        pkt_cnt_q;
    logic [15:0]       stall_cnt_q;
    logic [N_Q-1:0]    eligible;
    logic [N_Q-1:0]    grant;
    logic              sel_found;
    logic [QW-1:0]     sel;
    logic              hs;
    logic              pkt_done;

    // A queue may be granted only when it has a head beat and at least one credit.
    always_comb begin
        for (int i = 0; i < N_Q; i++) begin
            eligible[i] = ~q_empty_i[i] & (cred_q[i] != '0);
        end
    end

    // Round-robin scan: first eligible index starting at rr_ptr, wrapping modulo N_Q.
    always_comb begin
        logic [QW:0]   idx_w;
        logic [QW-1:0] idx;
        sel_found = 1'b0;
        sel       = '0;
        idx_w     = '0;
        idx       = '0;
        for (int k = 0; k < N_Q; k++) begin
            idx_w = {1'b0, rr_ptr_q} + (QW+1)'(k);
            if (idx_w >= (QW+1)'(N_Q)) begin
                idx_w = idx_w - (QW+1)'(N_Q);
            end
            idx = idx_w[QW-1:0];
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    // Next-state, grant and handshake decode.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_d       = cur_q;
        sop_pend_d  = sop_pend_q;
        grant       = '0;
        out_valid_o = 1'b0;
        q_rden_o    = '0;
        hs          = 1'b0;
        pkt_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant[sel] = 1'b1;
                    cur_d      = sel;
                    rr_ptr_d   = (sel == QW'(N_Q - 1)) ? '0 : sel + QW'(1);
                    sop_pend_d = 1'b1;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                out_valid_o     = ~q_empty_i[cur_q];
                hs              = out_valid_o & out_ready_i;
                q_rden_o[cur_q] = hs;
                if (hs) begin
                    sop_pend_d = 1'b0;
                    if (q_eop_i[cur_q]) begin
                        pkt_done = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers and debug counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cur_q       <= '0;
            sop_pend_q  <= 1'b1;
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_q      <= cur_d;
            sop_pend_q <= sop_pend_d;
            if (pkt_done) begin
                pkt_cnt_q <= pkt_cnt_q + 8'd1;
            end
            if (out_valid_o && !out_ready_i) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // Credit counters: grant consumes one, return adds one, saturating at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_Q; i++) begin
            if (rst) begin
                cred_q[i] <= CRED_W'(INIT_CRED);
            end else if (grant[i] && !cred_ret_i[i]) begin
                cred_q[i] <= cred_q[i] - CRED_W'(1);
            end else if (!grant[i] && cred_ret_i[i] && (cred_q[i] != '1)) begin
                cred_q[i] <= cred_q[i] + CRED_W'(1);
            end
        end
    end

    // Flatten credit counters onto the output bus.
    always_comb begin
        for (int i = 0; i < N_Q; i++) begin
            cred_o[i*CRED_W +: CRED_W] = cred_q[i];
        end
    end

    assign out_data_o = q_rdata_i[cur_q*DATA_WIDTH +: DATA_WIDTH];
    assign out_eop_o  = q_eop_i[cur_q];
    assign out_sop_o  = sop_pend_q;
    assign out_qid_o  = cur_q;
    assign busy_o     = (state_q == ST_XFER);
    assign debug_o    = {state_q, 6'(rr_ptr_q), pkt_cnt_q, stall_cnt_q};

endmodule

// File: tb/tb_tl_tx_sched.sv
// Directed bench for tl_tx_sched: behavioural queue model, vector table for the
// round-robin sweep, hand-written sequences for credits, stalls, underrun and reset.
module tb_tl_tx_sched;
    localparam int N_Q = 3;
    localparam int DW  = 256;
    localparam int CW  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_Q-1:0]    q_empty_i, q_eop_i, q_rden_o, cred_ret_i;
    logic [N_Q*DW-1:0] q_rdata_i;
    logic [N_Q*CW-1:0] cred_o;
    logic              out_valid_o, out_ready_i, out_sop_o, out_eop_o, busy_o;
    logic [DW-1:0]     out_data_o;
    logic [1:0]        out_qid_o;
    logic [31:0]       debug_o;

    always #5 clk = ~clk;

    tl_tx_sched #(.N_Q(N_Q), .DATA_WIDTH(DW), .CRED_W(CW), .INIT_CRED(8)) dut (
        .clk(clk), .rst(rst), .q_empty_i(q_empty_i), .q_rdata_i(q_rdata_i),
        .q_eop_i(q_eop_i), .q_rden_o(q_rden_o), .cred_ret_i(cred_ret_i),
        .cred_o(cred_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_sop_o(out_sop_o), .out_eop_o(out_eop_o),
        .out_qid_o(out_qid_o), .busy_o(busy_o), .debug_o(debug_o)
    );

    logic [15:0] mdat [N_Q][$];
    logic        meop [N_Q][$];
    logic        hide [N_Q];
    int nchk = 0, nerr = 0, pop_cnt = 0;

    typedef struct {
        logic        ready;
        logic        valid;
        logic        busy;
        logic [2:0]  rden;
        logic [1:0]  qid;
        logic        sop;
        logic        eop;
        logic [15:0] data;
    } vec_t;
    vec_t tv[19];

    function automatic vec_t mk(logic v, logic b, logic [2:0] r, logic [1:0] q,
                                logic s, logic e, logic [15:0] d);
        vec_t t;
        t.ready = 1'b1; t.valid = v; t.busy = b; t.rden = r;
        t.qid = q; t.sop = s; t.eop = e; t.data = d;
        return t;
    endfunction

    function automatic logic [CW-1:0] cred(int i);
        return cred_o[i*CW +: CW];
    endfunction

    task automatic drive_q();
        for (int i = 0; i < N_Q; i++) begin
            q_empty_i[i] = (mdat[i].size() == 0) || hide[i];
            q_rdata_i[i*DW +: DW] = (mdat[i].size() > 0) ? DW'(mdat[i][0]) : '0;
            q_eop_i[i] = (meop[i].size() > 0) ? meop[i][0] : 1'b0;
        end
    endtask

    task automatic push_pkt(input int q, input int p, input int n);
        for (int b = 0; b < n; b++) begin
            mdat[q].push_back(16'(q*64 + p*4 + b));
            meop[q].push_back(b == n - 1);
        end
        drive_q();
    endtask

    task automatic clear_q();
        for (int i = 0; i < N_Q; i++) begin
            mdat[i].delete();
            meop[i].delete();
            hide[i] = 1'b0;
        end
        drive_q();
    endtask

    // Advance one clock; queues pop on the rden seen before the edge.
    task automatic cycle();
        logic [N_Q-1:0] r;
        r = q_rden_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_Q; i++) begin
            if (r[i]) begin
                pop_cnt++;
                if (mdat[i].size() > 0) begin
                    void'(mdat[i].pop_front());
                    void'(meop[i].pop_front());
                end
            end
        end
        drive_q();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_sop(input int q, input int maxc);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < maxc && !ok; k++) begin
            #1;
            if (out_valid_o && out_sop_o && out_qid_o == 2'(q)) ok = 1'b1;
            else cycle();
        end
        check($sformatf("sop_q%0d_seen", q), 64'(ok), 64'd1);
    endtask

    initial begin
        int seen[$];
        logic [15:0] stall0;
        logic done;

        tv[0]  = mk(0, 0, 3'b000, 0, 0, 0, 0);
        tv[1]  = mk(1, 1, 3'b001, 0, 1, 0, 16'd0);
        tv[2]  = mk(1, 1, 3'b001, 0, 0, 1, 16'd1);
        tv[3]  = mk(0, 0, 3'b000, 0, 0, 0, 0);
        tv[4]  = mk(1, 1, 3'b010, 1, 1, 0, 16'd64);
        tv[5]  = mk(1, 1, 3'b010, 1, 0, 1, 16'd65);
        tv[6]  = mk(0, 0, 3'b000, 0, 0, 0, 0);
        tv[7]  = mk(1, 1, 3'b100, 2, 1, 0, 16'd128);
        tv[8]  = mk(1, 1, 3'b100, 2, 0, 1, 16'd129);
        tv[9]  = mk(0, 0, 3'b000, 0, 0, 0, 0);
        tv[10] = mk(1, 1, 3'b001, 0, 1, 0, 16'd4);
        tv[11] = mk(1, 1, 3'b001, 0, 0, 1, 16'd5);
        tv[12] = mk(0, 0, 3'b000, 0, 0, 0, 0);
        tv[13] = mk(1, 1, 3'b010, 1, 1, 0, 16'd68);
        tv[14] = mk(1, 1, 3'b010, 1, 0, 1, 16'd69);
        tv[15] = mk(0, 0, 3'b000, 0, 0, 0, 0);
        tv[16] = mk(1, 1, 3'b100, 2, 1, 0, 16'd132);
        tv[17] = mk(1, 1, 3'b100, 2, 0, 1, 16'd133);
        tv[18] = mk(0, 0, 3'b000, 0, 0, 0, 0);

        // Reset with all queues holding two 2-beat packets.
        rst = 1'b1; out_ready_i = 1'b1; cred_ret_i = '0;
        q_empty_i = '1; q_eop_i = '0; q_rdata_i = '0;
        clear_q();
        for (int q = 0; q < N_Q; q++) begin
            push_pkt(q, 0, 2);
            push_pkt(q, 1, 2);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_rden", 64'(q_rden_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        for (int i = 0; i < N_Q; i++) check($sformatf("rst_cred%0d", i), 64'(cred(i)), 64'd8);
        check("rst_debug", 64'(debug_o), 64'd0);
        rst = 1'b0;

        // Round-robin sweep from the vector table.
        for (int v = 0; v < 19; v++) begin
            logic [24:0] e, a;
            out_ready_i = tv[v].ready;
            #1;
            e = {tv[v].valid, tv[v].busy, tv[v].rden,
                 tv[v].valid ? {tv[v].qid, tv[v].sop, tv[v].eop, tv[v].data} : 20'd0};
            a = {out_valid_o, busy_o, q_rden_o,
                 tv[v].valid ? {out_qid_o, out_sop_o, out_eop_o, out_data_o[15:0]} : 20'd0};
            check($sformatf("vec%0d", v), 64'(a), 64'(e));
            cycle();
        end
        for (int i = 0; i < N_Q; i++) check($sformatf("rr_cred%0d", i), 64'(cred(i)), 64'd6);
        check("rr_pkt_cnt", 64'(debug_o[23:16]), 64'd6);
        check("rr_ptr", 64'(debug_o[29:24]), 64'd0);

        // Exhaust queue 1 credits with single-beat packets.
        for (int p = 0; p < 6; p++) push_pkt(1, p, 1);
        repeat (14) cycle();
        check("drain_cred1", 64'(cred(1)), 64'd0);
        check("drain_rr", 64'(debug_o[29:24]), 64'd2);
        push_pkt(0, 2, 1);
        push_pkt(1, 6, 1);
        push_pkt(2, 2, 1);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid_o && out_sop_o && out_ready_i) seen.push_back(int'(out_qid_o));
            cycle();
        end
        check("skip_count", 64'(seen.size()), 64'd2);
        check("skip_first", 64'((seen.size() > 0) ? seen[0] : 99), 64'd2);
        check("skip_second", 64'((seen.size() > 1) ? seen[1] : 99), 64'd0);
        check("skip_idle", 64'(busy_o), 64'd0);
        cred_ret_i[1] = 1'b1;
        #1;
        cycle();
        cred_ret_i[1] = 1'b0;
        check("ret_cred1", 64'(cred(1)), 64'd1);
        wait_sop(1, 5);
        check("ret_data", 64'(out_data_o[15:0]), 64'd88);
        cycle();
        cycle();

        // Downstream stall on beat 2 of a 4-beat packet from queue 2.
        pop_cnt = 0;
        stall0 = debug_o[15:0];
        push_pkt(2, 3, 4);
        wait_sop(2, 5);
        check("stall_b1", 64'(out_data_o[15:0]), 64'd140);
        cycle();
        out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall_hold%0d", k),
                  64'({out_valid_o, out_qid_o, out_eop_o, q_rden_o, out_data_o[15:0]}),
                  64'({1'b1, 2'd2, 1'b0, 3'b000, 16'd141}));
            cycle();
        end
        out_ready_i = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 6 && !done; k++) begin
            #1;
            if (out_valid_o && out_eop_o) done = 1'b1;
            cycle();
        end
        check("stall_done", 64'(done), 64'd1);
        check("stall_pops", 64'(pop_cnt), 64'd4);
        check("stall_cnt", 64'(debug_o[15:0] - stall0), 64'd5);

        // Queue 0 underruns after beat 1; queue 2 waits with a packet ready.
        push_pkt(0, 3, 3);
        wait_sop(0, 5);
        check("under_b1", 64'(out_data_o[15:0]), 64'd12);
        cycle();
        hide[0] = 1'b1;
        push_pkt(2, 4, 1);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("under_hold%0d", k),
                  64'({out_valid_o, busy_o, q_rden_o, out_qid_o}),
                  64'({1'b0, 1'b1, 3'b000, 2'd0}));
            cycle();
        end
        hide[0] = 1'b0;
        drive_q();
        #1;
        check("under_resume",
              64'({out_valid_o, out_sop_o, out_qid_o, out_data_o[15:0]}),
              64'({1'b1, 1'b0, 2'd0, 16'd13}));
        cycle();
        #1;
        check("under_last", 64'({out_eop_o, out_data_o[15:0]}), 64'({1'b1, 16'd14}));
        cycle();
        wait_sop(2, 4);
        check("under_next", 64'(out_data_o[15:0]), 64'd144);
        cycle();

        // Reset during beat 2 of a 3-beat packet.
        push_pkt(0, 4, 3);
        wait_sop(0, 5);
        cycle();
        rst = 1'b1;
        #1;
        cycle();
        check("mid_rst_out",
              64'({out_valid_o, busy_o, q_rden_o}), 64'd0);
        for (int i = 0; i < N_Q; i++) check($sformatf("mid_rst_cred%0d", i), 64'(cred(i)), 64'd8);
        check("mid_rst_rr", 64'(debug_o[29:24]), 64'd0);
        cycle();
        check("mid_rst_nopop", 64'(q_rden_o), 64'd0);
        clear_q();
        rst = 1'b0;
        cycle();

        // Grant and return on the same cycle leave the count unchanged.
        push_pkt(0, 5, 1);
        cred_ret_i[0] = 1'b1;
        #1;
        cycle();
        cred_ret_i[0] = 1'b0;
        #1;
        check("same_cyc_cred0", 64'({busy_o, cred(0)}), 64'({1'b1, 8'd8}));
        cycle();
        cycle();

        // Returns saturate at the top of the counter.
        cred_ret_i[2] = 1'b1;
        repeat (250) cycle();
        cred_ret_i[2] = 1'b0;
        check("sat_cred2", 64'(cred(2)), 64'd255);
        check("sat_cred1", 64'(cred(1)), 64'd8);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/tl_tx_sched.md
Name: tl_tx_sched

Overview:
Packet-atomic round-robin scheduler that drains N_Q transaction-layer queues (e.g. P / NP / CPL FIFOs, built without registered read data, so read data is valid combinationally whenever the queue is non-empty) into one outbound beat stream. It gates each queue on a per-queue header-credit counter and pops exactly one beat per accepted output beat. Once a packet is granted, all of its beats go out before another queue is considered. Sits between the TL queues and the DLL transmit interface.

Parameters:
N_Q, 3, number of source queues (2..8)
DATA_WIDTH, 256, beat width
CRED_W, 8, credit counter width
INIT_CRED, 8, per-queue credit value loaded at reset (must be < 2^CRED_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
q_empty_i  in  N_Q  per-queue empty flag
q_rdata_i  in  N_Q*DATA_WIDTH  per-queue head beat; queue i at [i*DATA_WIDTH +: DATA_WIDTH]
q_eop_i  in  N_Q  head beat of queue i is the last beat of its packet
q_rden_o  out  N_Q  pop strobe to queue i
cred_ret_i  in  N_Q  one header credit returned to queue i this cycle
cred_o  out  N_Q*CRED_W  current credit count per queue
out_valid_o  out  1  outbound beat valid
out_ready_i  in  1  downstream accepts beat
out_data_o  out  DATA_WIDTH  outbound beat
out_sop_o  out  1  first beat of packet
out_eop_o  out  1  last beat of packet
out_qid_o  out  $clog2(N_Q)  source queue of current beat
busy_o  out  1  state == XFER
debug_o  out  32  [31:30] state, [29:24] rr_ptr, [23:16] packet count mod 256, [15:0] stall cycles mod 2^16 (valid & ~ready)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rr_ptr=0, cur=0, sop_pend=1, all credits=INIT_CRED, counters=0. Outputs: out_valid_o=0, q_rden_o=0, busy_o=0.
- A reset in the middle of a packet aborts it. No further pops occur. The queues are reset by their owners.
- eligible[i] = ~q_empty_i[i] & (cred[i] != 0).
- IDLE:
  - If any queue is eligible, select the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo N_Q.
  - Register cur=sel, set rr_ptr=(sel+1) mod N_Q, decrement cred[sel], set sop_pend=1, and go to XFER.
  - If no queue is eligible, stay in IDLE.
  - No beat is output in IDLE. This gives a one-cycle arbitration bubble between packets.
- XFER, combinational outputs:
  - out_valid_o = ~q_empty_i[cur]
  - out_data_o = q_rdata_i[cur]
  - out_eop_o = q_eop_i[cur]
  - out_sop_o = sop_pend
  - out_qid_o = cur
- XFER, handshake:
  - q_rden_o[cur] = out_valid_o & out_ready_i. All other rden bits are 0.
  - On a handshake, sop_pend<=0.
  - On a handshake with eop, go to IDLE and increment the packet count.
  - If the queue goes empty mid-packet, hold in XFER with out_valid_o=0 and no timeout.
  - Credits are not re-checked mid-packet.
- Outside XFER and on every non-handshake cycle, out_valid_o=0 and q_rden_o=0. q_rden_o is never asserted when q_empty_i is set.
- Credit update per queue per cycle:
  - cred_next = cred - grant_i + cred_ret_i[i].
  - Simultaneous grant and return leaves the count unchanged.
  - A return at 2^CRED_W-1 saturates and is dropped.
  - A queue with credit 0 is never granted. A return makes it eligible the cycle after the return.
- Downstream stall (out_ready_i=0): out_data_o, out_sop_o, out_eop_o and out_qid_o stay stable while out_valid_o=1.
- Single-beat packet (eop on first beat): sop=eop=1 on the same beat.

Test Plan:
- Reset with all queues non-empty, rst=1 for 3 cycles -> out_valid_o=0, q_rden_o=0, cred_o=8 each. Rst low -> first grant to queue 0 one cycle later. out_sop_o=1 on the first beat.
- Queues 0, 1, 2 each hold two 2-beat packets, out_ready_i=1 -> packet order 0,1,2,0,1,2. Each packet is 2 beats plus 1 idle cycle. q_rden_o pulses once per beat. Final cred_o=6 each.
- Set cred[1]=0 (INIT_CRED=1, one grant consumed), queue 1 non-empty -> queue 1 skipped. Pulse cred_ret_i[1] -> queue 1 granted at its next round-robin turn.
- 4-beat packet on queue 2 with out_ready_i low on beats 2 and 3 for 5 cycles -> data, eop and qid held stable. No pop during the stall. Stall field increments by 5. Exactly 4 pops in total.
- Queue 0 goes empty after beat 1 of a 3-beat packet for 4 cycles -> out_valid_o=0, stays in XFER with busy_o=1, no grant to other queues. Packet resumes at beat 2 with out_sop_o=0.
- rst asserted during beat 2 of 3 -> next cycle out_valid_o=0, busy_o=0, credits back to 8, rr_ptr=0.
